// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel front-end: pixel width,
// luma coefficients and the 3x3 window byte index.
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int WIN_DIM    = 3;

  localparam int LUMA_R     = 77;
  localparam int LUMA_G     = 150;
  localparam int LUMA_B     = 29;
  localparam int LUMA_SHIFT = 8;

  typedef logic [PIX_W-1:0] pix_t;

  // Byte slot of p(r,c) inside the packed window; r=0 oldest line, c=0 oldest column.
  function automatic int win_idx(input int r, input int c);
    return WIN_DIM * r + c;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of luma history: single-port, read-before-write, combinational
// read at addr, write at the same addr on the rising edge.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  // The read returns the previous line's pixel before this edge overwrites it.
  assign rdata = mem[addr];

  // NOTE: memory contents are deliberately not reset; the window-valid
  // logic guarantees stale lines are never exposed after a restart.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// RGB-to-luma conversion, two cascaded line buffers and a 3x3 window shifter.
// Define SOBEL_WIN_LUMA_EN for weighted luma; otherwise the green channel is used.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PIX_W-1:0]                data_red_i,
  input  logic [PIX_W-1:0]                data_green_i,
  input  logic [PIX_W-1:0]                data_blue_i,
  input  logic                            data_done_i,
  output logic [WIN_DIM*WIN_DIM*PIX_W-1:0] win_o,
  output logic                            win_valid_o,
  output logic                            frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  pix_t          luma_next;
  pix_t          luma_q;
  logic          luma_vld;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pix_t          lb0_rd;
  pix_t          lb1_rd;
  logic          last_col;
  logic          last_row;

`ifdef SOBEL_WIN_LUMA_EN
  logic [15:0] luma_acc;
  // Worst case 255*256 = 65280 fits in 16 bits; the shift truncates.
  assign luma_acc  = 16'(LUMA_R) * {8'd0, data_red_i}
                   + 16'(LUMA_G) * {8'd0, data_green_i}
                   + 16'(LUMA_B) * {8'd0, data_blue_i};
  assign luma_next = PIX_W'(luma_acc >> LUMA_SHIFT);
`else
  logic unused_rb;
  assign unused_rb = ^{data_red_i, data_blue_i};
  assign luma_next = data_green_i;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      luma_q   <= '0;
      luma_vld <= 1'b0;
    end else begin
      luma_vld <= data_done_i;
      if (data_done_i) luma_q <= luma_next;
    end
  end

  assign last_col = (col == CW'(IMG_WIDTH - 1));
  assign last_row = (row == RW'(IMG_HEIGHT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (luma_vld) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk   (clk),
    .we    (luma_vld),
    .addr  (col),
    .wdata (luma_q),
    .rdata (lb1_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk   (clk),
    .we    (luma_vld),
    .addr  (col),
    .wdata (lb1_rd),
    .rdata (lb0_rd)
  );

  // Columns shift toward c=0; the new column is {oldest line .. newest sample}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_o        <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      win_valid_o  <= luma_vld && (row >= RW'(2)) && (col >= CW'(2));
      frame_done_o <= luma_vld && last_row && last_col;
      if (luma_vld) begin
        for (int r = 0; r < WIN_DIM; r++) begin
          for (int c = 0; c < WIN_DIM - 1; c++) begin
            win_o[PIX_W*win_idx(r, c) +: PIX_W] <= win_o[PIX_W*win_idx(r, c + 1) +: PIX_W];
          end
        end
        win_o[PIX_W*win_idx(0, 2) +: PIX_W] <= lb0_rd;
        win_o[PIX_W*win_idx(1, 2) +: PIX_W] <= lb1_rd;
        win_o[PIX_W*win_idx(2, 2) +: PIX_W] <= luma_q;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on an 8x4 image: a pixel-image
// model pushes expected windows into a scoreboard popped on win_valid_o.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 4;

  typedef struct {
    logic [71:0] win;
    logic        fd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  data_red_i;
  logic [7:0]  data_green_i;
  logic [7:0]  data_blue_i;
  logic        data_done_i;
  logic [71:0] win_o;
  logic        win_valid_o;
  logic        frame_done_o;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_red_i   (data_red_i),
    .data_green_i (data_green_i),
    .data_blue_i  (data_blue_i),
    .data_done_i  (data_done_i),
    .win_o        (win_o),
    .win_valid_o  (win_valid_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  int         win_cnt  = 0;
  int         m_row    = 0;
  int         m_col    = 0;
  logic       prev_v   = 1'b0;
  logic [7:0] img [H][W];
  exp_t       exp_q [$];
  int         fd_cyc [$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_luma(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
`ifdef SOBEL_WIN_LUMA_EN
    int s;
    s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
    return 8'(s / 256);
`else
    return g;
`endif
  endfunction

  // One clock: drive a sample (or a gap), then check what the DUT shows for
  // the sample driven one step earlier (two edges of latency).
  task automatic step(input logic v, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    logic        cur_v;
    logic [71:0] w;
    exp_t        e;
    cur_v        = 1'b0;
    data_done_i  = v;
    data_red_i   = r;
    data_green_i = g;
    data_blue_i  = b;
    if (v) begin
      img[m_row][m_col] = model_luma(r, g, b);
      if (m_row >= 2 && m_col >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[8*(3*i+j) +: 8] = img[m_row-2+i][m_col-2+j];
        e.win = w;
        e.fd  = (m_row == H-1) && (m_col == W-1);
        exp_q.push_back(e);
        cur_v = 1'b1;
      end
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("win_valid", 72'(win_valid_o), 72'(prev_v));
    if (win_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_win", 72'(1), 72'(0));
      end else begin
        e = exp_q.pop_front();
        check("win", win_o, e.win);
        check("frame_done", 72'(frame_done_o), 72'(e.fd));
        win_cnt++;
      end
    end else begin
      check("frame_done_idle", 72'(frame_done_o), 72'(0));
    end
    if (frame_done_o) fd_cyc.push_back(cyc);
    prev_v = cur_v;
  endtask

  // mode 0: constant 100, mode 1: luma specials on row 1, mode 2: ramp on G.
  task automatic send_frame(input int mode, input bit stall, input int n_pix);
    logic [7:0] r8, g8, b8;
    int n;
    n = 0;
    for (int rr = 0; rr < H; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        if (n >= n_pix) return;
        r8 = 8'($urandom_range(255));
        g8 = 8'($urandom_range(255));
        b8 = 8'($urandom_range(255));
        case (mode)
          0: begin r8 = 8'd100; g8 = 8'd100; b8 = 8'd100; end
          1: if (rr == 1) begin
               case (cc)
                 1: begin r8 = 8'd255; g8 = 8'd0;   b8 = 8'd0;   end
                 2: begin r8 = 8'd0;   g8 = 8'd255; b8 = 8'd0;   end
                 3: begin r8 = 8'd0;   g8 = 8'd0;   b8 = 8'd255; end
                 4: begin r8 = 8'd255; g8 = 8'd255; b8 = 8'd255; end
                 default: ;
               endcase
             end
          default: g8 = 8'(10 * rr + cc);
        endcase
        step(1'b1, r8, g8, b8);
        n++;
        if (stall && (n % 5 == 0))
          repeat (3) step(1'b0, 8'd0, 8'd0, 8'd0);
      end
    end
  endtask

  task automatic drain_and_count(input string tag, input int exp_wins, input int exp_fd);
    repeat (3) step(1'b0, 8'd0, 8'd0, 8'd0);
    check({tag, "_sb_empty"}, 72'(exp_q.size()), 72'(0));
    check({tag, "_win_count"}, 72'(win_cnt), 72'(exp_wins));
    check({tag, "_fd_count"}, 72'(fd_cyc.size()), 72'(exp_fd));
  endtask

  task automatic start_scenario();
    win_cnt = 0;
    fd_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win"}, win_o, 72'(0));
    check({tag, "_valid"}, 72'(win_valid_o), 72'(0));
    check({tag, "_fd"}, 72'(frame_done_o), 72'(0));
  endtask

  initial begin
    rst          = 1'b0;
    data_done_i  = 1'b0;
    data_red_i   = 8'd0;
    data_green_i = 8'd0;
    data_blue_i  = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;

    start_scenario();
    send_frame(0, 1'b0, W*H);
    drain_and_count("const", 12, 1);

    start_scenario();
    send_frame(1, 1'b0, W*H);
    drain_and_count("luma", 12, 1);

    start_scenario();
    send_frame(2, 1'b0, W*H);
    drain_and_count("ramp", 12, 1);

    start_scenario();
    send_frame(2, 1'b1, W*H);
    drain_and_count("stall", 12, 1);

    // Abort a ramp frame at row 2, col 4 with reset asserted mid-cycle.
    send_frame(2, 1'b0, 2*W + 4);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    prev_v = 1'b0;
    m_row  = 0;
    m_col  = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst = 1'b1;
    start_scenario();
    send_frame(2, 1'b0, W*H);
    drain_and_count("after_rst", 12, 1);

    start_scenario();
    send_frame(2, 1'b0, W*H);
    send_frame(0, 1'b0, W*H);
    drain_and_count("b2b", 24, 2);
    if (fd_cyc.size() == 2)
      check("b2b_fd_spacing", 72'(fd_cyc[1] - fd_cyc[0]), 72'(W*H));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
